// File: rtl/hilo_if.sv
// Bus between the EX stage and the HI/LO unit: ALU result capture,
// mfhi/mflo/mthi/mtlo requests, read data and the pipeline stall.
interface hilo_if;
  logic        valido;
  logic [3:0]  codigo_entrada;
  logic [63:0] Resultado;
  logic        le_hi;
  logic        le_lo;
  logic        escreve_hi;
  logic        escreve_lo;
  logic [31:0] dado_escrita;
  logic [31:0] saida;
  logic        saida_valida;
  logic        ocupado;
  logic        stall;

  modport master (
    output valido, codigo_entrada, Resultado,
    output le_hi, le_lo, escreve_hi, escreve_lo, dado_escrita,
    input  saida, saida_valida, ocupado, stall
  );

  modport slave (
    input  valido, codigo_entrada, Resultado,
    input  le_hi, le_lo, escreve_hi, escreve_lo, dado_escrita,
    output saida, saida_valida, ocupado, stall
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register unit: captures mult/div results from the ALU, commits them
// after a fixed latency, serves mfhi/mflo/mthi/mtlo and stalls while busy.
module hilo_unit #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 8
) (
  input  logic   clock,
  input  logic   reset,
  hilo_if.slave  bus
);

  localparam logic [3:0] OP_MULT  = 4'b0011;
  localparam logic [3:0] OP_DIV   = 4'b0100;
  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  typedef enum logic {OCIOSO, CONTANDO} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] saida_q, saida_d;
  logic        saida_valida_q, saida_valida_d;
  logic        ocupado_q, ocupado_d;
  logic        issue;
  logic        req;

  assign issue = bus.valido &&
                 ((bus.codigo_entrada == OP_MULT) || (bus.codigo_entrada == OP_DIV));
  assign req   = bus.le_hi | bus.le_lo | bus.escreve_hi | bus.escreve_lo | issue;

  assign bus.stall        = ocupado_q & req;
  assign bus.saida        = saida_q;
  assign bus.saida_valida = saida_valida_q;
  assign bus.ocupado      = ocupado_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pend_d         = pend_q;
    hi_d           = hi_q;
    lo_d           = lo_q;
    saida_d        = saida_q;
    saida_valida_d = 1'b0;
    ocupado_d      = ocupado_q;

    case (state_q)
      OCIOSO: begin
        // Reads sample the pre-edge registers, so a same-cycle write is not seen.
        if (bus.le_hi) begin
          saida_d        = hi_q;
          saida_valida_d = 1'b1;
        end else if (bus.le_lo) begin
          saida_d        = lo_q;
          saida_valida_d = 1'b1;
        end

        if (issue) begin
          pend_d    = bus.Resultado;
          cnt_d     = (bus.codigo_entrada == OP_MULT) ? MULT_CNT : DIV_CNT;
          state_d   = CONTANDO;
          ocupado_d = 1'b1;
        end else begin
          if (bus.escreve_hi) hi_d = bus.dado_escrita;
          if (bus.escreve_lo) lo_d = bus.dado_escrita;
        end
      end

      CONTANDO: begin
        // Every request stalls here, so only the countdown and commit happen.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d      = pend_q[63:32];
          lo_d      = pend_q[31:0];
          state_d   = OCIOSO;
          ocupado_d = 1'b0;
        end
      end

      default: begin
        state_d   = OCIOSO;
        ocupado_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= OCIOSO;
      cnt_q          <= '0;
      pend_q         <= '0;
      hi_q           <= '0;
      lo_q           <= '0;
      saida_q        <= '0;
      saida_valida_q <= 1'b0;
      ocupado_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pend_q         <= pend_d;
      hi_q           <= hi_d;
      lo_q           <= lo_d;
      saida_q        <= saida_d;
      saida_valida_q <= saida_valida_d;
      ocupado_q      <= ocupado_d;
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: directed vector table, hand-written latency/stall/reset
// sequences and random traffic, all checked against a time-stamped model.
module tb_hilo_unit;
  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hilo_if bus ();

  hilo_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic        val;
    logic [3:0]  cod;
    logic [63:0] res;
    logic        lh;
    logic        ll;
    logic        wh;
    logic        wl;
    logic [31:0] dat;
  } in_t;

  typedef struct {
    in_t         i;
    logic [31:0] e_saida;
    logic        e_sv;
    logic        e_oc;
    logic        e_st;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: HI/LO, pending value and the absolute edge number of the commit.
  int          cyc = 0;
  int          m_commit_at = -1;
  logic [31:0] m_hi = '0, m_lo = '0, m_saida = '0;
  logic [63:0] m_pend = '0;
  logic        m_sv = 1'b0;

  logic [31:0] a_saida;
  logic        a_sv, a_oc, a_st;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic in_t mi(input logic rst, input logic val, input logic [3:0] cod,
                             input logic [63:0] res, input logic lh, input logic ll,
                             input logic wh, input logic wl, input logic [31:0] dat);
    in_t r;
    r.rst = rst; r.val = val; r.cod = cod; r.res = res;
    r.lh = lh; r.ll = ll; r.wh = wh; r.wl = wl; r.dat = dat;
    return r;
  endfunction

  function automatic vec_t mv(input in_t i, input logic [31:0] s, input logic sv,
                              input logic oc, input logic st);
    vec_t r;
    r.i = i; r.e_saida = s; r.e_sv = sv; r.e_oc = oc; r.e_st = st;
    return r;
  endfunction

  function automatic logic is_issue(input in_t v);
    return v.val && (v.cod == 4'd3 || v.cod == 4'd4);
  endfunction

  task automatic model_edge(input in_t v);
    int   k;
    logic busy;
    k    = cyc + 1;
    busy = (m_commit_at > cyc);
    m_sv = 1'b0;
    if (v.rst) begin
      m_hi = '0; m_lo = '0; m_pend = '0; m_saida = '0; m_commit_at = -1;
    end else if (busy) begin
      if (k == m_commit_at) begin
        m_hi = m_pend[63:32];
        m_lo = m_pend[31:0];
      end
    end else begin
      if (v.lh) begin m_saida = m_hi; m_sv = 1'b1; end
      else if (v.ll) begin m_saida = m_lo; m_sv = 1'b1; end
      if (is_issue(v)) begin
        m_pend      = v.res;
        m_commit_at = k + ((v.cod == 4'd3) ? MULT_LAT : DIV_LAT);
      end else begin
        if (v.wh) m_hi = v.dat;
        if (v.wl) m_lo = v.dat;
      end
    end
    cyc = k;
  endtask

  // One clock cycle: drive, check stall before the edge, check registers after.
  task automatic run_cycle(input in_t v);
    logic exp_st;
    reset                  = v.rst;
    bus.valido             = v.val;
    bus.codigo_entrada     = v.cod;
    bus.Resultado          = v.res;
    bus.le_hi              = v.lh;
    bus.le_lo              = v.ll;
    bus.escreve_hi         = v.wh;
    bus.escreve_lo         = v.wl;
    bus.dado_escrita       = v.dat;
    #2;
    exp_st = (m_commit_at > cyc) && (v.lh || v.ll || v.wh || v.wl || is_issue(v));
    a_st   = bus.stall;
    chk("stall", {63'd0, a_st}, {63'd0, exp_st});
    @(posedge clock);
    model_edge(v);
    #1;
    a_saida = bus.saida;
    a_sv    = bus.saida_valida;
    a_oc    = bus.ocupado;
    chk("saida", {32'd0, a_saida}, {32'd0, m_saida});
    chk("saida_valida", {63'd0, a_sv}, {63'd0, m_sv});
    chk("ocupado", {63'd0, a_oc}, {63'd0, (m_commit_at > cyc)});
  endtask

  vec_t tbl[$];
  in_t  idle, v;
  int   nst;

  initial begin
    idle = mi(0, 0, 4'd0, 64'd0, 0, 0, 0, 0, 32'd0);
    reset = 1'b1;
    bus.valido = 0; bus.codigo_entrada = '0; bus.Resultado = '0;
    bus.le_hi = 0; bus.le_lo = 0; bus.escreve_hi = 0; bus.escreve_lo = 0;
    bus.dado_escrita = '0;
    @(posedge clock); #1;

    tbl.push_back(mv(mi(1, 0, 4'd0, 64'd0, 0, 0, 0, 0, 32'd0), 32'h0, 0, 0, 0));
    tbl.push_back(mv(mi(0, 0, 4'd0, 64'd0, 1, 0, 0, 0, 32'd0), 32'h0, 1, 0, 0));
    tbl.push_back(mv(mi(0, 0, 4'd0, 64'd0, 0, 1, 0, 0, 32'd0), 32'h0, 1, 0, 0));
    tbl.push_back(mv(idle, 32'h0, 0, 0, 0));
    tbl.push_back(mv(mi(0, 1, 4'd3, 64'h0000_0001_FFFF_FFFE, 0, 0, 0, 0, 32'd0), 32'h0, 0, 1, 0));
    tbl.push_back(mv(idle, 32'h0, 0, 1, 0));
    tbl.push_back(mv(idle, 32'h0, 0, 1, 0));
    tbl.push_back(mv(idle, 32'h0, 0, 1, 0));
    tbl.push_back(mv(idle, 32'h0, 0, 0, 0));
    tbl.push_back(mv(mi(0, 0, 4'd0, 64'd0, 1, 0, 0, 0, 32'd0), 32'h0000_0001, 1, 0, 0));
    tbl.push_back(mv(mi(0, 0, 4'd0, 64'd0, 0, 1, 0, 0, 32'd0), 32'hFFFF_FFFE, 1, 0, 0));
    tbl.push_back(mv(mi(0, 0, 4'd0, 64'd0, 1, 0, 1, 0, 32'hDEAD_BEEF), 32'h0000_0001, 1, 0, 0));
    tbl.push_back(mv(mi(0, 0, 4'd0, 64'd0, 1, 0, 0, 0, 32'd0), 32'hDEAD_BEEF, 1, 0, 0));
    tbl.push_back(mv(mi(0, 0, 4'd0, 64'd0, 0, 1, 0, 0, 32'd0), 32'hFFFF_FFFE, 1, 0, 0));
    tbl.push_back(mv(mi(0, 0, 4'd0, 64'd0, 0, 0, 1, 1, 32'h1234_5678), 32'hFFFF_FFFE, 0, 0, 0));
    tbl.push_back(mv(mi(0, 0, 4'd0, 64'd0, 0, 1, 0, 0, 32'd0), 32'h1234_5678, 1, 0, 0));
    tbl.push_back(mv(mi(0, 0, 4'd0, 64'd0, 1, 0, 0, 0, 32'd0), 32'h1234_5678, 1, 0, 0));
    tbl.push_back(mv(mi(0, 1, 4'd3, 64'h1111_1111_2222_2222, 1, 0, 1, 0, 32'hAAAA_AAAA),
                     32'h1234_5678, 1, 1, 0));
    tbl.push_back(mv(mi(0, 0, 4'd0, 64'd0, 0, 1, 0, 0, 32'd0), 32'h1234_5678, 0, 1, 1));
    tbl.push_back(mv(idle, 32'h1234_5678, 0, 1, 0));
    tbl.push_back(mv(idle, 32'h1234_5678, 0, 1, 0));
    tbl.push_back(mv(idle, 32'h1234_5678, 0, 0, 0));
    tbl.push_back(mv(mi(0, 0, 4'd0, 64'd0, 1, 0, 0, 0, 32'd0), 32'h1111_1111, 1, 0, 0));
    tbl.push_back(mv(mi(0, 0, 4'd0, 64'd0, 0, 1, 0, 0, 32'd0), 32'h2222_2222, 1, 0, 0));
    tbl.push_back(mv(mi(0, 1, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 32'd0), 32'h2222_2222, 0, 0, 0));
    tbl.push_back(mv(mi(0, 0, 4'd0, 64'd0, 1, 1, 0, 0, 32'd0), 32'h1111_1111, 1, 0, 0));

    foreach (tbl[n]) begin
      run_cycle(tbl[n].i);
      chk($sformatf("tbl%0d_stall", n), {63'd0, a_st}, {63'd0, tbl[n].e_st});
      chk($sformatf("tbl%0d_saida", n), {32'd0, a_saida}, {32'd0, tbl[n].e_saida});
      chk($sformatf("tbl%0d_sv", n), {63'd0, a_sv}, {63'd0, tbl[n].e_sv});
      chk($sformatf("tbl%0d_oc", n), {63'd0, a_oc}, {63'd0, tbl[n].e_oc});
    end

    // Divide with a waiting mflo: stalls for DIV_LAT cycles, then reads LO.
    run_cycle(mi(0, 1, 4'd4, 64'h0000_0002_0000_000E, 0, 0, 0, 0, 32'd0));
    nst = 0;
    for (int c = 0; c < 20; c++) begin
      run_cycle(mi(0, 0, 4'd0, 64'd0, 0, 1, 0, 0, 32'd0));
      if (a_st) nst++;
      if (a_sv) break;
    end
    chk("div_stall_cycles", 64'(nst), 64'(DIV_LAT));
    chk("div_lo", {32'd0, a_saida}, 64'h0000_000E);
    chk("div_lo_valid", {63'd0, a_sv}, 64'd1);

    // Mult held while busy: accepted only after the first one commits.
    run_cycle(mi(0, 1, 4'd3, 64'hAAAA_0000_BBBB_0000, 0, 0, 0, 0, 32'd0));
    nst = 0;
    for (int c = 0; c < 20; c++) begin
      run_cycle(mi(0, 1, 4'd3, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 32'd0));
      if (!a_st) break;
      nst++;
    end
    chk("mult_busy_stalls", 64'(nst), 64'(MULT_LAT));
    for (int c = 0; c < MULT_LAT; c++) run_cycle(idle);
    run_cycle(mi(0, 0, 4'd0, 64'd0, 1, 0, 0, 0, 32'd0));
    chk("mult2_hi", {32'd0, a_saida}, 64'h0123_4567);
    run_cycle(mi(0, 0, 4'd0, 64'd0, 0, 1, 0, 0, 32'd0));
    chk("mult2_lo", {32'd0, a_saida}, 64'h89AB_CDEF);

    // Reset two cycles into a divide discards it; HI/LO stay zero.
    run_cycle(mi(0, 1, 4'd4, 64'h5555_5555_6666_6666, 0, 0, 0, 0, 32'd0));
    run_cycle(idle);
    run_cycle(idle);
    run_cycle(mi(1, 0, 4'd0, 64'd0, 0, 0, 0, 0, 32'd0));
    chk("rst_ocupado", {63'd0, a_oc}, 64'd0);
    for (int c = 0; c < 12; c++) run_cycle(idle);
    chk("rst_no_commit_oc", {63'd0, a_oc}, 64'd0);
    run_cycle(mi(0, 0, 4'd0, 64'd0, 1, 0, 0, 0, 32'd0));
    chk("rst_hi", {32'd0, a_saida}, 64'd0);
    run_cycle(mi(0, 0, 4'd0, 64'd0, 0, 1, 0, 0, 32'd0));
    chk("rst_lo", {32'd0, a_saida}, 64'd0);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      v.rst = ($urandom_range(0, 80) == 0);
      v.val = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0:       v.cod = 4'd3;
        1:       v.cod = 4'd4;
        default: v.cod = 4'($urandom_range(0, 15));
      endcase
      v.res = {$urandom, $urandom};
      v.lh  = ($urandom_range(0, 3) == 0);
      v.ll  = ($urandom_range(0, 3) == 0);
      v.wh  = ($urandom_range(0, 4) == 0);
      v.wl  = ($urandom_range(0, 4) == 0);
      v.dat = $urandom;
      run_cycle(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Sequential HI/LO register unit directly downstream of the ALU.
- Captures the ALU's 64-bit Resultado for multiply (codigo 0011) and divide (codigo 0100) and commits it to HI/LO after a parameterised latency.
- Serves mfhi/mflo/mthi/mtlo and raises a pipeline stall while a result is pending.

Parameters:
- MULT_LAT, 4: cycles from multiply issue to HI/LO commit (legal range 1..15).
- DIV_LAT, 8: cycles from divide issue to HI/LO commit (legal range 1..15).

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- valido  input  1  ALU result valid this cycle (instruction issued in EX).
- codigo_entrada  input  4  ALU operation code; only 0011 (mult) and 0100 (div) are acted on.
- Resultado  input  64  ALU result; [63:32] goes to HI, [31:0] goes to LO (div: remainder to HI, quotient to LO).
- le_hi  input  1  mfhi request.
- le_lo  input  1  mflo request.
- escreve_hi  input  1  mthi request.
- escreve_lo  input  1  mtlo request.
- dado_escrita  input  32  data for mthi/mtlo.
- saida  output  32  registered read data.
- saida_valida  output  1  one-cycle pulse; saida holds new read data.
- ocupado  output  1  registered; a mult/div is pending.
- stall  output  1  combinational; upstream must hold the current instruction.

Behaviour:
- Reset: HI=0, LO=0, pending register=0, counter=0, state OCIOSO, saida=0, saida_valida=0, ocupado=0. Reset mid-operation discards the pending result, and HI/LO stay 0.
- States: OCIOSO, CONTANDO.
- Issue (in OCIOSO, valido=1, codigo 0011 or 0100):
  - Latch Resultado into the pending register.
  - Load the counter with MULT_LAT or DIV_LAT.
  - Go to CONTANDO; ocupado=1 from the next cycle.
- Other codigo values with valido=1 are ignored.
- CONTANDO:
  - Counter decrements each cycle.
  - On the edge where the counter goes 1 to 0, commit HI/LO from the pending register, return to OCIOSO, and drop ocupado.
  - An op issued at edge t commits at edge t+LAT; ocupado is high for exactly LAT cycles.
- stall = ocupado AND (le_hi OR le_lo OR escreve_hi OR escreve_lo OR (valido AND codigo in {0011,0100})).
  - While stalled, the request is not accepted, and no state other than the counter changes.
- Reads (not stalled):
  - le_hi: saida <= HI and saida_valida <= 1 at the next edge.
  - le_lo: same, returning LO.
  - le_hi and le_lo together are illegal; le_hi wins.
  - saida holds its last value when there is no read; saida_valida is 0 otherwise.
- Writes (not stalled):
  - escreve_hi: HI <= dado_escrita at the edge.
  - escreve_lo: LO <= dado_escrita at the edge.
  - Both in the same cycle write both registers.
- Simultaneous events in OCIOSO:
  - Read plus write of the same register: the read returns the old value (pre-edge).
  - Issue plus mthi/mtlo: the issue is accepted and the write is ignored (illegal combination).
- The first read after commit (one cycle after ocupado falls) returns the committed value. No back-to-back result forwarding.
- Divide-by-zero: the unit commits whatever Resultado carried; no exception is raised.

Test Plan:
- Reset then le_hi and le_lo on consecutive cycles -> saida=0 both times, saida_valida pulses once each.
- Mult issue, Resultado=64'h0000_0001_FFFF_FFFE, MULT_LAT=4 -> ocupado high 4 cycles; then le_hi gives 32'h0000_0001 and le_lo gives 32'hFFFF_FFFE.
- Div issue, Resultado=64'h0000_0002_0000_000E, DIV_LAT=8; le_lo asserted from cycle 1 -> stall=1 for cycles 1..8; saida=32'h0000_000E with saida_valida one cycle after stall falls.
- Mult issued while ocupado -> stall=1, pending and counter unaffected; accepted the cycle after ocupado falls, committing after a further MULT_LAT cycles.
- escreve_hi with dado_escrita=32'hDEAD_BEEF and le_hi the same cycle -> saida=old HI; the next le_hi returns 32'hDEAD_BEEF.
- Reset asserted 2 cycles into an 8-cycle div -> ocupado=0, HI=LO=0 after reset; no commit occurs later.
